dcache_wb_ctrl: RTL and testbench

- Write-back, direct-mapped data cache controller. It is the responder on the CPU data-memory port: it accepts byte reads and writes from the CPU and stalls the CPU with BUSYWAIT.
- It is also the initiator toward block-wide data memory.
- Geometry: 8 lines x 4 bytes, 8-bit byte address. Address split: tag[7:5], index[4:2], offset[1:0].
- Sits between the CPU load/store path and the main data memory model.

---
 rtl/dcache_wb_ctrl_if.sv | 46 ++++
 rtl/dcache_wb_ctrl.sv | 111 +++++++++++
 tb/tb_dcache_wb_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_ctrl_if.sv
// CPU data port and block memory port of the write-back data cache.
// The slave side is the cache; the master side drives CPU and memory.
interface dcache_wb_ctrl_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ,
    input  WRITE,
    input  ADDRESS,
    input  WRITEDATA,
    output READDATA,
    output BUSYWAIT,
    output MEM_READ,
    output MEM_WRITE,
    output MEM_ADDRESS,
    output MEM_WRITEDATA,
    input  MEM_READDATA,
    input  MEM_BUSYWAIT
  );

  modport master (
    output READ,
    output WRITE,
    output ADDRESS,
    output WRITEDATA,
    input  READDATA,
    input  BUSYWAIT,
    input  MEM_READ,
    input  MEM_WRITE,
    input  MEM_ADDRESS,
    input  MEM_WRITEDATA,
    output MEM_READDATA,
    output MEM_BUSYWAIT
  );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// Write-back direct-mapped data cache controller, 8 lines x 4 bytes.
// Hits complete with no stall; misses write back a dirty line, then fetch.
module dcache_wb_ctrl (
  input logic             CLK,
  input logic             RESET,
  dcache_wb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_e;

  state_e      state_q;
  logic [31:0] data_q [8];
  logic [2:0]  tag_q [8];
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [31:0] block_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [5:0]  mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [2:0]  tag_a;
  logic [2:0]  idx;
  logic [1:0]  off;
  logic [4:0]  bsel;
  logic [31:0] line;
  logic        req;
  logic        hit;

  assign tag_a = bus.ADDRESS[7:5];
  assign idx   = bus.ADDRESS[4:2];
  assign off   = bus.ADDRESS[1:0];
  assign bsel  = {off, 3'b000};
  assign line  = data_q[idx];
  assign req   = bus.READ | bus.WRITE;
  assign hit   = valid_q[idx] && (tag_q[idx] == tag_a);

  assign bus.BUSYWAIT = req && !(state_q == IDLE && hit);
  assign bus.READDATA = (bus.READ && hit && !RESET)
                        ? line[bsel +: 8] : 8'h00;

  assign bus.MEM_READ      = mem_rd_q;
  assign bus.MEM_WRITE     = mem_wr_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;

  // Controller FSM: hit writes, line writeback, block fetch and refill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      block_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && !hit) begin
            if (dirty_q[idx]) begin
              state_q     <= WRITEBACK;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx};
              mem_wdata_q <= line;
            end else begin
              state_q    <= FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= bus.ADDRESS[7:2];
            end
          end else if (bus.WRITE && hit) begin
            data_q[idx][bsel +: 8] <= bus.WRITEDATA;
            dirty_q[idx]           <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q     <= FETCH;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= bus.ADDRESS[7:2];
            mem_wdata_q <= '0;
          end
        end
        FETCH: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q    <= UPDATE;
            block_q    <= bus.MEM_READDATA;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        UPDATE: begin
          state_q      <= IDLE;
          data_q[idx]  <= block_q;
          tag_q[idx]   <= tag_a;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Bench for dcache_wb_ctrl: CPU accesses and memory transfers are
// checked against expectations queued when each access is issued.
module tb_dcache_wb_ctrl;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mexp_t;

  typedef struct {
    logic       chk_rd;
    logic [7:0] rdata;
    int         stall;
  } cexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mcnt = 0;
  int   mreq_cyc = 0;
  logic [31:0] mem [64];
  mexp_t mem_q [$];
  cexp_t cpu_q [$];

  dcache_wb_ctrl_if bus ();

  dcache_wb_ctrl dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Memory model: each request stalls for 3 cycles, done in the 4th.
  assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (mcnt != 3);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

  always @(posedge clk) begin
    if (bus.MEM_READ | bus.MEM_WRITE) begin
      if (!bus.MEM_BUSYWAIT) begin
        if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
        mcnt <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Memory-side monitor: compares each completed transfer.
  always @(negedge clk) begin
    if (bus.MEM_READ | bus.MEM_WRITE) mreq_cyc++;
    if ((bus.MEM_READ | bus.MEM_WRITE) && !bus.MEM_BUSYWAIT && !rst) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected", 32'(bus.MEM_ADDRESS), 32'hFFFF_FFFF);
      end else begin
        mexp_t e;
        e = mem_q.pop_front();
        chk("mem_wr", 32'(bus.MEM_WRITE), 32'(e.wr));
        chk("mem_rd", 32'(bus.MEM_READ), 32'(!e.wr));
        chk("mem_addr", 32'(bus.MEM_ADDRESS), 32'(e.addr));
        if (e.wr) chk("mem_wdata", bus.MEM_WRITEDATA, e.data);
      end
    end
  end

  task automatic mexp(input logic wr, input logic [5:0] a,
                      input logic [31:0] d);
    mexp_t e;
    e.wr = wr;
    e.addr = a;
    e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic access(input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic chk_rd, input logic [7:0] exp_rd,
                        input int exp_stall);
    cexp_t e;
    int st;
    e.chk_rd = chk_rd;
    e.rdata = exp_rd;
    e.stall = exp_stall;
    cpu_q.push_back(e);
    @(negedge clk);
    bus.READ = rd;
    bus.WRITE = wr;
    bus.ADDRESS = a;
    bus.WRITEDATA = d;
    #1;
    st = 0;
    while (bus.BUSYWAIT && st < 60) begin
      st++;
      @(negedge clk);
      #1;
    end
    e = cpu_q.pop_front();
    if (bus.BUSYWAIT) chk("access_timeout", 32'(st), 32'(e.stall));
    chk("stall", 32'(st), 32'(e.stall));
    if (e.chk_rd) chk("rdata", 32'(bus.READDATA), 32'(e.rdata));
    @(posedge clk);
    #1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  initial begin
    int b;
    int t;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]    = 32'h4433_2211;
    mem[1]    = 32'h0D0C_0B0A;
    mem[8]    = 32'h8877_6655;
    mem[9]    = 32'h1122_3344;
    mem[16]   = 32'hCCBB_AA99;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDRESS = 8'h00;
    bus.WRITEDATA = 8'h00;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.BUSYWAIT), 0);
    chk("rst_mrd", 32'(bus.MEM_READ), 0);
    chk("rst_mwr", 32'(bus.MEM_WRITE), 0);
    chk("rst_maddr", 32'(bus.MEM_ADDRESS), 0);
    chk("rst_mwdata", bus.MEM_WRITEDATA, 0);
    chk("rst_rdata", 32'(bus.READDATA), 0);
    rst = 1'b0;

    mexp(1'b0, 6'h00, 32'h0);
    access(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 6);
    access(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 8'h44, 0);

    b = mreq_cyc;
    access(1'b0, 1'b1, 8'h01, 8'hAB, 1'b0, 8'h00, 0);
    chk("whit_mem_idle", 32'(mreq_cyc), 32'(b));
    access(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'hAB, 0);

    mexp(1'b1, 6'h00, 32'h4433_AB11);
    mexp(1'b0, 6'h08, 32'h0);
    access(1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 8'h66, 10);

    mexp(1'b0, 6'h10, 32'h0);
    access(1'b1, 1'b0, 8'h41, 8'h00, 1'b1, 8'hAA, 6);

    @(negedge clk);
    bus.READ = 1'b1;
    bus.ADDRESS = 8'h05;
    t = 0;
    while (!bus.MEM_READ && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("fetch_started", 32'(bus.MEM_READ), 1);
    rst = 1'b1;
    bus.READ = 1'b0;
    @(negedge clk);
    chk("rst_fetch_mrd", 32'(bus.MEM_READ), 0);
    rst = 1'b0;

    mexp(1'b0, 6'h01, 32'h0);
    access(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h0B, 6);

    b = mreq_cyc;
    access(1'b1, 1'b1, 8'h06, 8'h5A, 1'b0, 8'h00, 0);
    chk("rw_mem_idle", 32'(mreq_cyc), 32'(b));
    access(1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'h5A, 0);

    mexp(1'b1, 6'h01, 32'h0D5A_0B0A);
    mexp(1'b0, 6'h09, 32'h0);
    access(1'b1, 1'b0, 8'h25, 8'h00, 1'b1, 8'h33, 10);

    repeat (2) @(negedge clk);
    chk("mem_q_empty", 32'(mem_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
